sram_port_arbiter: RTL and testbench

- Shares one single-ported synchronous SRAM (1-cycle read latency) between the instruction-fetch port and the data-memory port of the pipeline.
- Sequences each access: writes take 1 cycle, reads take 2 cycles.
- Raises a per-requester stall until that requester's access completes, and arbitrates conflicting requests.
- Sits between the CPU core's fetch/memory stages and the shared SRAM.

---
 rtl/sram_port_arbiter.sv | 107 ++++++++++
 tb/tb_sram_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported synchronous SRAM between the fetch and data ports.
// Writes complete in the grant cycle; reads hold a one-cycle RD_WAIT for the SRAM latency.
module sram_port_arbiter #(
  parameter int unsigned ARB_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_stall,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_stall,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;            // 0 = inst, 1 = data
  logic   last_grant_q, last_grant_d;
  logic   winner;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    winner       = 1'b0;
    inst_rdata   = '0;
    inst_stall   = 1'b0;
    data_rdata   = '0;
    data_stall   = 1'b0;
    sram_en      = 1'b0;
    sram_wen     = '0;
    sram_addr    = '0;
    sram_wdata   = '0;

    // Outputs are forced quiet while reset is held, even if a read was in flight.
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (inst_en || data_en) begin
            if (inst_en && data_en) begin
              winner = (ARB_MODE == 1) ? 1'b1 : ~last_grant_q;
            end else begin
              winner = data_en;
            end
            last_grant_d = winner;
            sram_en      = 1'b1;
            if (winner) begin
              sram_wen   = data_wen;
              sram_addr  = data_addr;
              sram_wdata = data_wdata;
              inst_stall = inst_en;
              if (data_wen == 4'b0000) begin
                data_stall = 1'b1;
                owner_d    = 1'b1;
                state_d    = StRdWait;
              end
            end else begin
              sram_addr  = inst_addr;
              inst_stall = 1'b1;
              data_stall = data_en;
              owner_d    = 1'b0;
              state_d    = StRdWait;
            end
          end
        end
        StRdWait: begin
          sram_en = 1'b1;
          state_d = StIdle;
          if (owner_q) begin
            sram_addr  = data_addr;
            data_rdata = sram_rdata;
            inst_stall = inst_en;
          end else begin
            sram_addr  = inst_addr;
            inst_rdata = sram_rdata;
            data_stall = data_en;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model with its own memory image.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_mem = 1'b0;
  logic        inst_en = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        data_en = 1'b0;
  logic [3:0]  data_wen = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;

  logic [31:0] inst_rdata0, data_rdata0, sram_addr0, sram_wdata0, rd0;
  logic        inst_stall0, data_stall0, sram_en0;
  logic [3:0]  sram_wen0;
  logic [31:0] inst_rdata1, data_rdata1, sram_addr1, sram_wdata1;
  logic        inst_stall1, data_stall1, sram_en1;
  logic [3:0]  sram_wen1;

  localparam logic [31:0] Rd1Const = 32'h1357_9BDF;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] mem0 [16];
  logic [31:0] model_mem [16];

  always #5 clk = ~clk;

  sram_port_arbiter #(.ARB_MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata0), .inst_stall(inst_stall0),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata0), .data_stall(data_stall0),
    .sram_en(sram_en0), .sram_wen(sram_wen0), .sram_addr(sram_addr0), .sram_wdata(sram_wdata0),
    .sram_rdata(rd0)
  );

  sram_port_arbiter #(.ARB_MODE(1)) dut1 (
    .clk(clk), .rst(rst),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata1), .inst_stall(inst_stall1),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata1), .data_stall(data_stall1),
    .sram_en(sram_en1), .sram_wen(sram_wen1), .sram_addr(sram_addr1), .sram_wdata(sram_wdata1),
    .sram_rdata(Rd1Const)
  );

  function automatic logic [31:0] pat(int i);
    return 32'hDEADBEEF ^ (i * 32'h0001_1111);
  endfunction

  // Behavioural single-ported SRAM with one-cycle read latency for dut0.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) mem0[i] <= pat(i);
    end else if (sram_en0) begin
      if (sram_wen0 == 4'b0000) begin
        rd0 <= mem0[sram_addr0[5:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (sram_wen0[b]) mem0[sram_addr0[5:2]][8*b +: 8] <= sram_wdata0[8*b +: 8];
      end
    end
  end

  task automatic idle_inputs();
    inst_en = 1'b0; inst_addr = '0;
    data_en = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; init_mem = 1'b1; idle_inputs();
    @(negedge clk);
    @(negedge clk); rst = 1'b0; init_mem = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; init_mem = 1'b1; idle_inputs(); #2;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({sram_en0, sram_wen0, sram_addr0, sram_wdata0, inst_stall0, data_stall0,
           inst_rdata0, data_rdata0} !== '0) begin
        n_fail++;
        $display("FAIL reset_%0d: got en=%b wen=%h addr=%h is=%b ds=%b, need all zero",
                 k, sram_en0, sram_wen0, sram_addr0, inst_stall0, data_stall0);
      end
      @(negedge clk);
      if (k == 1) begin rst = 1'b0; init_mem = 1'b0; end
      #2;
    end
  endtask

  task automatic test_inst_read();
    do_reset();
    @(negedge clk); inst_en = 1'b1; inst_addr = 32'h100; #2;
    n_cmp++;
    if ({inst_stall0, sram_en0, sram_addr0, sram_wen0} !== {1'b1, 1'b1, 32'h100, 4'h0}) begin
      n_fail++;
      $display("FAIL inst_read_c0: got stall=%b en=%b addr=%h wen=%h, need 1 1 00000100 0",
               inst_stall0, sram_en0, sram_addr0, sram_wen0);
    end
    @(negedge clk); #2;
    n_cmp++;
    if ({inst_stall0, inst_rdata0} !== {1'b0, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL inst_read_c1: got stall=%b rdata=%h, need 0 deadbeef", inst_stall0, inst_rdata0);
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_data_write();
    do_reset();
    @(negedge clk); data_en = 1'b1; data_wen = 4'b0011; data_addr = 32'h200;
    data_wdata = 32'h1234; #2;
    n_cmp++;
    if ({sram_en0, sram_wen0, sram_addr0, sram_wdata0, data_stall0} !==
        {1'b1, 4'b0011, 32'h200, 32'h1234, 1'b0}) begin
      n_fail++;
      $display("FAIL data_write: got en=%b wen=%h addr=%h wdata=%h stall=%b, need 1 3 200 1234 0",
               sram_en0, sram_wen0, sram_addr0, sram_wdata0, data_stall0);
    end
    // A fetch right after must be granted from IDLE and see the byte-merged word.
    @(negedge clk); idle_inputs(); inst_en = 1'b1; inst_addr = 32'h100; #2;
    n_cmp++;
    if ({inst_stall0, sram_addr0, sram_wen0} !== {1'b1, 32'h100, 4'h0}) begin
      n_fail++;
      $display("FAIL write_then_idle: got stall=%b addr=%h wen=%h, need 1 00000100 0",
               inst_stall0, sram_addr0, sram_wen0);
    end
    @(negedge clk); #2;
    n_cmp++;
    if ({inst_stall0, inst_rdata0} !== {1'b0, 32'hDEAD1234}) begin
      n_fail++;
      $display("FAIL byte_merge: got stall=%b rdata=%h, need 0 dead1234", inst_stall0, inst_rdata0);
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_conflict();
    do_reset();
    @(negedge clk); inst_en = 1'b1; inst_addr = 32'h10; data_en = 1'b1; data_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      #2;
      n_cmp++;
      case (k)
        0: if ({data_stall0, inst_stall0, sram_addr0} !== {1'b1, 1'b1, 32'h20}) begin
             n_fail++;
             $display("FAIL conflict_c0: got ds=%b is=%b addr=%h, need 1 1 20",
                      data_stall0, inst_stall0, sram_addr0);
           end
        1: if ({data_stall0, inst_stall0, data_rdata0} !== {1'b0, 1'b1, pat(8)}) begin
             n_fail++;
             $display("FAIL conflict_c1: got ds=%b is=%b rd=%h, need 0 1 %h",
                      data_stall0, inst_stall0, data_rdata0, pat(8));
           end
        2: if ({inst_stall0, sram_addr0} !== {1'b1, 32'h10}) begin
             n_fail++;
             $display("FAIL conflict_c2: got is=%b addr=%h, need 1 10", inst_stall0, sram_addr0);
           end
        default: if ({inst_stall0, inst_rdata0} !== {1'b0, pat(4)}) begin
             n_fail++;
             $display("FAIL conflict_c3: got is=%b rd=%h, need 0 %h", inst_stall0, inst_rdata0, pat(4));
           end
      endcase
      @(negedge clk);
      if (k == 1) data_en = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ga;
    logic        gd, ph;
    do_reset();
    @(negedge clk); inst_en = 1'b1; inst_addr = 32'h10; data_en = 1'b1; data_addr = 32'h20;
    for (int k = 0; k < 8; k++) begin
      #2;
      gd = ((k / 2) % 2) == 0;
      ph = (k % 2) == 1;
      ga = gd ? 32'h20 : 32'h10;
      n_cmp++;
      if ({sram_addr0, inst_stall0, data_stall0} !== {ga, (gd | !ph), (!gd | !ph)}) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: got addr=%h is=%b ds=%b, need %h %b %b",
                 k, sram_addr0, inst_stall0, data_stall0, ga, gd | !ph, !gd | !ph);
      end
      n_cmp++;
      if ({sram_en1, sram_wen1, sram_addr1, sram_wdata1, inst_stall1, data_stall1,
           inst_rdata1, data_rdata1} !==
          {1'b1, 4'h0, 32'h20, 32'h0, 1'b1, !ph, 32'h0, (ph ? Rd1Const : 32'h0)}) begin
        n_fail++;
        $display("FAIL fixed_prio_%0d: got addr=%h is=%b ds=%b drd=%h, need 20 1 %b",
                 k, sram_addr1, inst_stall1, data_stall1, data_rdata1, !ph);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    @(negedge clk); inst_en = 1'b1; inst_addr = 32'h100; #2;
    n_cmp++;
    if (inst_stall0 !== 1'b1) begin
      n_fail++; $display("FAIL midrst_grant: got is=%b need 1", inst_stall0);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); rst = (k == 0); inst_en = 1'b0; #2;
      n_cmp++;
      if ({sram_en0, sram_wen0, sram_addr0, sram_wdata0, inst_stall0, data_stall0,
           inst_rdata0, data_rdata0} !== '0) begin
        n_fail++;
        $display("FAIL midrst_quiet_%0d: got en=%b addr=%h is=%b rd=%h, need all zero",
                 k, sram_en0, sram_addr0, inst_stall0, inst_rdata0);
      end
    end
    @(negedge clk); inst_en = 1'b1; #2;
    n_cmp++;
    if ({inst_stall0, sram_en0, sram_addr0} !== {1'b1, 1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL midrst_reissue: got is=%b en=%b addr=%h, need 1 1 100",
               inst_stall0, sram_en0, sram_addr0);
    end
    @(negedge clk); #2;
    n_cmp++;
    if ({inst_stall0, inst_rdata0} !== {1'b0, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL midrst_data: got is=%b rd=%h, need 0 deadbeef", inst_stall0, inst_rdata0);
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_owner_flush();
    do_reset();
    @(negedge clk); data_en = 1'b1; data_addr = 32'h20;
    @(negedge clk); data_en = 1'b0; inst_en = 1'b1; inst_addr = 32'h10; #2;
    n_cmp++;
    if ({sram_en0, sram_addr0, data_stall0, inst_stall0} !== {1'b1, 32'h20, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_rdwait: got en=%b addr=%h ds=%b is=%b, need 1 20 0 1",
               sram_en0, sram_addr0, data_stall0, inst_stall0);
    end
    @(negedge clk); #2;
    n_cmp++;
    if ({inst_stall0, sram_addr0} !== {1'b1, 32'h10}) begin
      n_fail++; $display("FAIL flush_next_grant: got is=%b addr=%h, need 1 10", inst_stall0, sram_addr0);
    end
    @(negedge clk); #2;
    n_cmp++;
    if ({inst_stall0, inst_rdata0} !== {1'b0, pat(4)}) begin
      n_fail++;
      $display("FAIL flush_inst_done: got is=%b rd=%h, need 0 %h", inst_stall0, inst_rdata0, pat(4));
    end
    @(negedge clk); idle_inputs();
  endtask

  // Transaction model: which port (if any) is waiting on read data, and who got the last grant.
  task automatic test_random();
    int          busy_port = -1;
    logic        last_data = 1'b0;
    logic        hold_i = 1'b0, hold_d = 1'b0, gd;
    logic        e_en, e_is, e_ds;
    logic [3:0]  e_wen;
    logic [31:0] e_addr, e_wd, e_ri, e_rd;
    do_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = pat(i);
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 63) == 0);
      if (!hold_i) begin
        inst_en = 1'($urandom_range(0, 1)); inst_addr = $urandom & 32'hFFFF_FFFC;
      end else if ($urandom_range(0, 7) == 0) inst_en = 1'b0;
      if (!hold_d) begin
        data_en = 1'($urandom_range(0, 1)); data_addr = $urandom & 32'hFFFF_FFFC;
        data_wen = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
        data_wdata = $urandom;
      end else if ($urandom_range(0, 7) == 0) data_en = 1'b0;

      e_en = 0; e_wen = 0; e_addr = 0; e_wd = 0; e_is = 0; e_ds = 0; e_ri = 0; e_rd = 0; gd = 0;
      if (!rst) begin
        if (busy_port == 1) begin
          e_en = 1; e_addr = data_addr; e_rd = model_mem[data_addr[5:2]]; e_is = inst_en;
        end else if (busy_port == 0) begin
          e_en = 1; e_addr = inst_addr; e_ri = model_mem[inst_addr[5:2]]; e_ds = data_en;
        end else if (inst_en || data_en) begin
          gd = data_en && (!inst_en || !last_data);
          e_en = 1;
          if (gd) begin
            e_addr = data_addr; e_wen = data_wen; e_wd = data_wdata;
            e_is = inst_en; e_ds = (data_wen == 4'h0);
          end else begin
            e_addr = inst_addr; e_is = 1; e_ds = data_en;
          end
        end
      end
      #2;
      n_cmp++;
      if ({sram_en0, sram_wen0, sram_addr0, sram_wdata0, inst_stall0, data_stall0,
           inst_rdata0, data_rdata0} !== {e_en, e_wen, e_addr, e_wd, e_is, e_ds, e_ri, e_rd}) begin
        n_fail++;
        $display("FAIL random_%0d: got en=%b wen=%h a=%h wd=%h is=%b ds=%b ri=%h rd=%h, need %b %h %h %h %b %b %h %h",
                 cyc, sram_en0, sram_wen0, sram_addr0, sram_wdata0, inst_stall0, data_stall0,
                 inst_rdata0, data_rdata0, e_en, e_wen, e_addr, e_wd, e_is, e_ds, e_ri, e_rd);
      end
      if (rst) begin
        busy_port = -1; last_data = 1'b0;
      end else if (busy_port >= 0) begin
        busy_port = -1;
      end else if (inst_en || data_en) begin
        last_data = gd;
        if (gd && data_wen != 4'h0) begin
          for (int b = 0; b < 4; b++)
            if (data_wen[b]) model_mem[data_addr[5:2]][8*b +: 8] = data_wdata[8*b +: 8];
        end else begin
          busy_port = gd ? 1 : 0;
        end
      end
      hold_i = e_is;
      hold_d = e_ds;
    end
    @(negedge clk); rst = 1'b0; idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_inst_read();
    test_data_write();
    test_conflict();
    test_back_to_back();
    test_reset_mid_read();
    test_owner_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
